multi_cycle_alu: RTL and testbench

//  Execute stage that consumes alu_op/btype from the ALU control unit and operands from the register file or immediate path.

---
 rtl/multi_cycle_alu_pkg.sv | 37 +++
 rtl/multi_cycle_alu_if.sv | 50 +++++
 rtl/multi_cycle_alu_branch_comparator.sv | 24 ++
 rtl/multi_cycle_alu.sv | 145 ++++++++++++++
 tb/tb_multi_cycle_alu.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_alu_pkg.sv
// Shared encodings for the multi-cycle execute stage.
// ALU function codes, branch compare types and FSM states.
package multi_cycle_alu_pkg;

  typedef enum logic [3:0] {
    FUNC_ADD = 4'h0,
    FUNC_SUB = 4'h1,
    FUNC_AND = 4'h2,
    FUNC_OR  = 4'h3,
    FUNC_XOR = 4'h4,
    FUNC_LLS = 4'h5,
    FUNC_LRS = 4'h6,
    FUNC_ARS = 4'h7
  } alu_func_e;

  typedef enum logic [1:0] {
    BRANCH_EQ = 2'd0,
    BRANCH_NE = 2'd1,
    BRANCH_LT = 2'd2,
    BRANCH_GE = 2'd3
  } branch_e;

  typedef enum logic [1:0] {
    ALU_ST_IDLE  = 2'd0,
    ALU_ST_SHIFT = 2'd1,
    ALU_ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(
    input logic [3:0] op
  );
    return (op == FUNC_LLS) ||
           (op == FUNC_LRS) ||
           (op == FUNC_ARS);
  endfunction

endpackage

// File: rtl/multi_cycle_alu_if.sv
// Operand/result handshake bundle for the execute stage.
// slave = the ALU, master = the control/consumer side.
interface multi_cycle_alu_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            alu_op;
  logic [1:0]            btype;
  logic                  is_branch;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  bcond;
  logic                  busy;

  modport slave (
    input  in_valid,
    input  alu_op,
    input  btype,
    input  is_branch,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output alu_result,
    output bcond,
    output busy
  );

  modport master (
    output in_valid,
    output alu_op,
    output btype,
    output is_branch,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  alu_result,
    input  bcond,
    input  busy
  );

endinterface

// File: rtl/multi_cycle_alu_branch_comparator.sv
// Combinational branch condition evaluator.
// Signed compares are done directly so a-b overflow cannot corrupt LT/GE.
module multi_cycle_alu_branch_comparator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            btype,
  output logic                  bcond
);

  import multi_cycle_alu_pkg::*;

  always_comb begin
    bcond = 1'b0;
    unique case (btype)
      BRANCH_EQ: bcond = (a == b);
      BRANCH_NE: bcond = (a != b);
      BRANCH_LT: bcond = ($signed(a) < $signed(b));
      BRANCH_GE: bcond = ($signed(a) >= $signed(b));
    endcase
  end

endmodule

// File: rtl/multi_cycle_alu.sv
// Execute stage: single-cycle ALU ops, bit-serial shifts,
// branch compare, valid/ready on both sides.
module multi_cycle_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  multi_cycle_alu_if.slave    bus
);

  import multi_cycle_alu_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int SW = SHAMT_WIDTH;

  alu_state_e      state_q;
  alu_state_e      state_d;
  logic [3:0]      op_q;
  logic [SW-1:0]   cnt_q;
  logic [DW-1:0]   work_q;
  logic [DW-1:0]   result_q;
  logic            bcond_q;

  logic            accept;
  logic [SW-1:0]   shamt;
  logic            start_shift;
  logic            last_shift;
  logic [DW-1:0]   dp_result;
  logic            dp_bcond;
  logic            br_taken;
  logic [DW-1:0]   shift_next;

  assign accept = bus.in_valid &&
                  (state_q == ALU_ST_IDLE);
  assign shamt  = bus.in_b[SW-1:0];

  // Branches take priority over any op code.
  assign start_shift = !bus.is_branch &&
                       is_shift(bus.alu_op) &&
                       (shamt != '0);

  assign last_shift = (cnt_q == SW'(1));

  multi_cycle_alu_branch_comparator #(
    .DATA_WIDTH(DW)
  ) u_cmp (
    .a     (bus.in_a),
    .b     (bus.in_b),
    .btype (bus.btype),
    .bcond (br_taken)
  );

  always_comb begin
    dp_result = '0;
    dp_bcond  = 1'b0;
    if (bus.is_branch) begin
      dp_result = bus.in_a - bus.in_b;
      dp_bcond  = br_taken;
    end else begin
      unique case (1'b1)
        bus.alu_op == FUNC_ADD:
          dp_result = bus.in_a + bus.in_b;
        bus.alu_op == FUNC_SUB:
          dp_result = bus.in_a - bus.in_b;
        bus.alu_op == FUNC_AND:
          dp_result = bus.in_a & bus.in_b;
        bus.alu_op == FUNC_OR:
          dp_result = bus.in_a | bus.in_b;
        bus.alu_op == FUNC_XOR:
          dp_result = bus.in_a ^ bus.in_b;
        is_shift(bus.alu_op):
          dp_result = bus.in_a;
        default:
          dp_result = '0;
      endcase
    end
  end

  always_comb begin
    shift_next = work_q;
    unique case (1'b1)
      op_q == FUNC_LLS:
        shift_next = {work_q[DW-2:0], 1'b0};
      op_q == FUNC_LRS:
        shift_next = {1'b0, work_q[DW-1:1]};
      default:
        shift_next = {work_q[DW-1], work_q[DW-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ALU_ST_IDLE:
        if (accept)
          state_d = start_shift ? ALU_ST_SHIFT
                                : ALU_ST_DONE;
      ALU_ST_SHIFT:
        if (last_shift)
          state_d = ALU_ST_DONE;
      ALU_ST_DONE:
        if (bus.out_ready)
          state_d = ALU_ST_IDLE;
      default:
        state_d = ALU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ALU_ST_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      bcond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.alu_op;
        if (start_shift) begin
          work_q  <= bus.in_a;
          cnt_q   <= shamt;
          bcond_q <= 1'b0;
        end else begin
          result_q <= dp_result;
          bcond_q  <= dp_bcond;
        end
      end else if (state_q == ALU_ST_SHIFT) begin
        work_q <= shift_next;
        cnt_q  <= cnt_q - 1'b1;
        if (last_shift)
          result_q <= shift_next;
      end
    end
  end

  assign bus.in_ready   = (state_q == ALU_ST_IDLE);
  assign bus.out_valid  = (state_q == ALU_ST_DONE);
  assign bus.busy       = (state_q != ALU_ST_IDLE);
  assign bus.alu_result = result_q;
  assign bus.bcond      = bcond_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed bench for multi_cycle_alu with a reference
// model feeding an expected-result queue.
module tb_multi_cycle_alu;

  import multi_cycle_alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  multi_cycle_alu_if #(.DATA_WIDTH(32)) bus ();

  multi_cycle_alu #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        bc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h",
                tag, obs, exp);
  endtask

  function automatic exp_t model(
    input logic [3:0]  op,
    input logic [1:0]  bt,
    input logic        br,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.res = 32'h0;
    e.bc  = 1'b0;
    e.lat = 1;
    if (br) begin
      e.res = a - b;
      case (bt)
        BRANCH_EQ: e.bc = (a == b);
        BRANCH_NE: e.bc = (a != b);
        BRANCH_LT: e.bc = ($signed(a) < $signed(b));
        default:   e.bc = ($signed(a) >= $signed(b));
      endcase
    end else begin
      case (op)
        FUNC_ADD: e.res = a + b;
        FUNC_SUB: e.res = a - b;
        FUNC_AND: e.res = a & b;
        FUNC_OR:  e.res = a | b;
        FUNC_XOR: e.res = a ^ b;
        FUNC_LLS: begin
          e.res = a << sh;
          e.lat = sh + 1;
        end
        FUNC_LRS: begin
          e.res = a >> sh;
          e.lat = sh + 1;
        end
        FUNC_ARS: begin
          e.res = $signed(a) >>> sh;
          e.lat = sh + 1;
        end
        default: e.res = 32'h0;
      endcase
    end
    return e;
  endfunction

  task automatic drive(
    input logic [3:0]  op,
    input logic [1:0]  bt,
    input logic        br,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    bus.alu_op    = op;
    bus.btype     = bt;
    bus.is_branch = br;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    chk("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(op, bt, br, a, b));
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 64) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    chk({tag, "_res"}, bus.alu_result, e.res);
    chk({tag, "_bcond"}, 32'(bus.bcond), 32'(e.bc));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = 4'h0;
    bus.btype     = 2'd0;
    bus.is_branch = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;

    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.alu_result, 32'h0);
    chk("rst_bcond", 32'(bus.bcond), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    drive(FUNC_ADD, 2'd0, 1'b0, 32'h7FFF_FFFF, 32'h1);
    collect("add_wrap");
    drive(FUNC_SUB, 2'd0, 1'b0, 32'h0, 32'h1);
    collect("sub_wrap");
    drive(FUNC_AND, 2'd0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
    collect("and");
    drive(FUNC_OR, 2'd0, 1'b0, 32'hA000_0001, 32'h0500_0010);
    collect("or");
    drive(FUNC_ARS, 2'd0, 1'b0, 32'hF000_0000, 32'h4);
    collect("ars4");
    drive(FUNC_LLS, 2'd0, 1'b0, 32'h1234_5678, 32'h0);
    collect("lls0");
    drive(FUNC_LLS, 2'd0, 1'b0, 32'h8000_0003, 32'h3);
    collect("lls3");
    drive(FUNC_LRS, 2'd0, 1'b0, 32'h8000_0000, 32'hFFFF_FFE2);
    collect("lrs2");
    drive(FUNC_ADD, BRANCH_LT, 1'b1, 32'hFFFF_FFFF, 32'h1);
    collect("blt");
    drive(FUNC_ADD, BRANCH_GE, 1'b1, 32'h8000_0000, 32'h1);
    collect("bge_neg");
    drive(FUNC_ADD, BRANCH_GE, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    collect("bge_ovf");
    drive(FUNC_ADD, BRANCH_EQ, 1'b1, 32'h5, 32'h5);
    collect("beq");
    drive(FUNC_ADD, BRANCH_NE, 1'b1, 32'h5, 32'h5);
    collect("bne");
    drive(4'hF, 2'd0, 1'b0, 32'hDEAD_BEEF, 32'h1);
    collect("undef");

    drive(FUNC_XOR, 2'd0, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF);
    chk("bp_valid0", 32'(bus.out_valid), 32'd1);
    held = bus.alu_result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.alu_op   = FUNC_SUB;
      bus.in_a     = 32'h1;
      bus.in_b     = 32'h1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold", bus.alu_result, held);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    collect("bp_xor");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("bp_no_queue", 32'(bus.out_valid), 32'd0);
    end

    drive(FUNC_LRS, 2'd0, 1'b0, 32'h8000_0000, 32'd31);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", bus.alu_result, 32'h0);
    chk("abort_bcond", 32'(bus.bcond), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    drive(FUNC_XOR, 2'd0, 1'b0, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    collect("xor_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
